// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 codes, LSU FSM states and latency limit for mem_lsu.
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int LAT_MAX = 4;
  localparam int CNT_W = $clog2(LAT_MAX);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t;
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: EX/MEM request and MEM/WB response signals of the load/store unit.
interface mem_lsu_if;
  logic        valid_i;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic        mem_we;
  logic        mem_ren;
  logic [2:0]  funct3;
  logic        stall;
  logic [31:0] mem_rdata;
  logic        rdata_valid;
  logic        misalign;
  modport master (output valid_i, alu_result, rs2_data, mem_we, mem_ren, funct3,
                  input stall, mem_rdata, rdata_valid, misalign);
  modport slave  (input valid_i, alu_result, rs2_data, mem_we, mem_ren, funct3,
                  output stall, mem_rdata, rdata_valid, misalign);
endinterface

// File: rtl/dmem_pipe.sv
// dmem_pipe: byte-enabled data memory with a LOAD_LATENCY-deep read register chain.
module dmem_pipe #(
  parameter int ADDR_WIDTH   = 10,
  parameter int LOAD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] pipe [LOAD_LATENCY];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < LOAD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= mem[addr];
      for (int i = 1; i < LOAD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  assign rdata = pipe[LOAD_LATENCY-1];
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: RV32 load/store unit with stall handshake; define MEM_MISALIGN_TRAP_EN to trap
// misaligned accesses instead of silently aligning them.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int LOAD_LATENCY = 1
) (
  input logic      clk,
  input logic      reset,
  mem_lsu_if.slave bus
);
  lsu_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       a_raw, a, a_q;
  logic [2:0]       f3_q;
  logic             is_h, is_w, req, trap, accept, load_go;
  logic [3:0]       be;
  logic [31:0]      wdata, w, fmt, held;
  logic [7:0]       b;
  logic [15:0]      h;
  logic             unused_hi;
  assign unused_hi = ^bus.alu_result[31:ADDR_WIDTH+2];
  assign a_raw = bus.alu_result[1:0];
  assign is_h  = bus.funct3[1:0] == 2'b01;
  assign is_w  = bus.funct3[1:0] == 2'b10;
  assign req   = state == IDLE && bus.valid_i && (bus.mem_we || bus.mem_ren);
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = req && ((is_h && a_raw[0]) || (is_w && a_raw != 2'b00));
  assign a    = a_raw;
`else
  assign trap = 1'b0;
  assign a    = is_w ? 2'b00 : is_h ? {a_raw[1], 1'b0} : a_raw;
`endif
  assign accept  = req && !trap;
  assign load_go = accept && bus.mem_ren;
  assign be    = is_w ? 4'b1111 : is_h ? 4'b0011 << {a[1], 1'b0} : 4'b0001 << a;
  assign wdata = is_w ? bus.rs2_data : is_h ? {2{bus.rs2_data[15:0]}} : {4{bus.rs2_data[7:0]}};
  dmem_pipe #(.ADDR_WIDTH(ADDR_WIDTH), .LOAD_LATENCY(LOAD_LATENCY)) u_dmem (
    .clk   (clk),
    .reset (reset),
    .we    (accept && bus.mem_we),
    .be    (be),
    .addr  (bus.alu_result[ADDR_WIDTH+1:2]),
    .wdata (wdata),
    .rdata (w)
  );
  // a latency-1 load has no WAIT cycle: data is already at the chain output next cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (load_go) begin
        state_n = LOAD_LATENCY > 1 ? WAIT : DONE;
        cnt_n   = CNT_W'(LOAD_LATENCY - 1);
      end
      WAIT: begin
        cnt_n   = cnt - 1'b1;
        state_n = cnt == CNT_W'(1) ? DONE : WAIT;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      f3_q  <= '0;
      held  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load_go) a_q <= a;
      if (load_go) f3_q <= bus.funct3;
      if (state == DONE) held <= fmt;
    end
  assign b   = 8'(w >> {a_q, 3'b000});
  assign h   = a_q[1] ? w[31:16] : w[15:0];
  assign fmt = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & b[7]}}, b} :
               f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & h[15]}}, h} : w;
  assign bus.stall       = load_go || state == WAIT;
  assign bus.rdata_valid = state == DONE;
  assign bus.mem_rdata   = state == DONE ? fmt : held;
  assign bus.misalign    = trap;
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised successor to the MEM pipeline stage. It adds a full RV32 load/store unit: sub-word accesses selected by funct3, byte-lane steering, sign/zero extension, configurable data-memory read latency with a pipeline stall handshake, and optional misalignment trapping. It sits between the EX/MEM and MEM/WB pipeline registers and owns the data memory instance.

## Interface
- ADDR_WIDTH, 10: word-address bits. Memory holds 2^ADDR_WIDTH 32-bit words.
- LOAD_LATENCY, 1: cycles from load acceptance to data return. Legal range 1..4.
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high. Clears all state except memory contents.
- valid_i  input  1  EX/MEM holds a valid instruction.
- alu_result  input  32  effective byte address.
- rs2_data  input  32  store data, right-aligned.
- mem_we  input  1  store.
- mem_ren  input  1  load. Never asserted together with mem_we.
- funct3  input  3  access size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- stall  output  1  hold EX/MEM and everything upstream this cycle.
- mem_rdata  output  32  formatted load result. Holds the last value until the next load completes.
- rdata_valid  output  1  one-cycle pulse when mem_rdata is updated.
- misalign  output  1  misaligned access flag. Combinational, qualified by acceptance.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- Acceptance: a request is accepted only in IDLE when valid_i & (mem_we | mem_ren) and the access is not trapped.
- Store: committed in the acceptance cycle. No stall, FSM stays in IDLE.
  - Byte enables: SB gives 4'b0001 << addr[1:0]; SH gives 4'b0011 << {addr[1],1'b0}; SW gives 4'b1111.
  - Write data is lane-replicated: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
- Load: read issued in the acceptance cycle; FSM enters WAIT with counter = LOAD_LATENCY-1.
  - WAIT decrements the counter and moves to DONE when the counter reaches 0.
  - DONE lasts exactly one cycle, then returns to IDLE.
- Load formatting from the returned word w, using registered addr[1:0] and funct3:
  - LB/LBU: byte w[8*a +: 8], sign- or zero-extended.
  - LH/LHU: halfword w[16*a[1] +: 16], sign- or zero-extended.
  - LW: w.
- Inputs are ignored in WAIT and DONE. The upstream pipeline holds them stable while stall=1. In DONE the held load instruction is retired, not re-accepted.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. Handling per Configuration.
- Reset mid-operation: FSM returns to IDLE immediately. In-flight read data is discarded and no rdata_valid pulse is produced for it.

## Timing
- Reset values: stall=0, rdata_valid=0, mem_rdata=0, misalign=0, counter=0.
- stall = (IDLE & load accepted) | WAIT. This is combinational and high for exactly LOAD_LATENCY cycles per load.
- rdata_valid=1 and mem_rdata is updated in the DONE cycle. stall=0 in that cycle.
- A store presented in the DONE cycle's successor (IDLE) is accepted there. Back-to-back loads cost LOAD_LATENCY+1 cycles each.
- A store is readable by a load accepted in the next cycle.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access in IDLE with valid_i asserts misalign for that cycle.
  - The access is suppressed: no write, no FSM transition, no stall.
- MEM_MISALIGN_TRAP_EN undefined:
  - misalign is tied 0.
  - Offending low address bits are cleared to natural alignment and the access proceeds normally.

## Structure
- Package mem_pkg holds:
  - funct3 localparams;
  - lsu_state_t enum {IDLE, WAIT, DONE};
  - the LOAD_LATENCY maximum constant (4).
- Sub-module dmem_pipe(ADDR_WIDTH, LOAD_LATENCY) provides:
  - a byte-enabled synchronous write port;
  - a read port with a LOAD_LATENCY-deep output register chain.
- Byte-lane steering and load formatting stay in mem_lsu.

## Test plan
- LOAD_LATENCY=2, SW 0xDEADBEEF @0x40, then LW @0x40 -> stall high 2 cycles, then rdata_valid=1 with mem_rdata=0xDEADBEEF.
- SB 0x80 @0x41 -> word reads 0xDEAD80EF. LB @0x41 -> 0xFFFFFF80. LBU @0x41 -> 0x00000080.
- SH 0x1234 @0x42, then LHU @0x42 -> 0x00001234. LH @0x40 -> 0xFFFF80EF.
- LW @0x41:
  - with MEM_MISALIGN_TRAP_EN -> misalign=1 for one cycle, stall=0, no rdata_valid;
  - without it -> returns the word @0x40.
- Reset asserted in WAIT -> stall=0 immediately, no rdata_valid. After release, LW @0x40 completes normally.
- LW followed by an SW held during stall -> SW accepted only in the IDLE cycle after DONE. The memory is unchanged until then.
